// File: rtl/store_buffer_pkg.sv
// Shared widths and the buffered-store entry type for the posted-write store buffer.
package store_buffer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  // Word-granular address: the byte offset is never stored.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:2] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_sb_match.sv
// DEPTH-way word-address compare over buffered stores; picks the youngest hit.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   tail,
  input  logic [ADDR_W-1:2]          lookup_addr,
  output logic                       hit,
  output logic [$clog2(DEPTH)-1:0]   idx
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] pos;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last hit seen wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned k = DEPTH; k > 0; k--) begin
      pos = tail - PW'(k);
      if (entries[pos].valid && (entries[pos].addr == lookup_addr)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues stores, drains them when no load owns the
// Data_mem port, and forwards the youngest matching buffered store to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   MemRead_ex_mm,
  input  logic                   MemWrite_ex_mm,
  input  logic [DATA_W-1:0]      foutput2_ex_mm,
  input  logic                   flush_ex_mm,
  input  logic                   mem_ready,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [ADDR_W-1:0]      mem_address,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [DATA_W-1:0]      load_data,
  output logic                   stall,
  output logic                   sb_empty,
  output logic [$clog2(DEPTH):0] sb_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t     entries_q [DEPTH];
  sb_entry_t     entries_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          ld, st, drain, enq, full, busy;
  logic          hit;
  logic [PW-1:0] hit_idx;

  assign ld   = MemRead_ex_mm & ~MemWrite_ex_mm & ~flush_ex_mm;
  assign st   = MemWrite_ex_mm & ~flush_ex_mm;
  assign busy = (count_q != '0);
  assign full = (count_q == CW'(DEPTH));

  sb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .entries     (entries_q),
    .tail        (tail_q),
    .lookup_addr (address[ADDR_W-1:2]),
    .hit         (hit),
    .idx         (hit_idx)
  );

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    drain       = 1'b0;
    load_data   = '0;
    if (ld) begin
      mem_read    = 1'b1;
      mem_address = address;
      load_data   = hit ? entries_q[hit_idx].data : mem_rdata;
    end else if (busy) begin
      mem_write   = 1'b1;
      mem_address = {entries_q[head_q].addr, 2'b00};
      mem_wdata   = entries_q[head_q].data;
      drain       = mem_ready;
    end
  end

  assign enq      = st & (~full | drain);
  assign stall    = st & full & ~drain;
  assign sb_empty = ~busy;
  assign sb_count = count_q;

  // When full and draining, tail == head: the drained slot is refilled in the
  // same cycle, so the enqueue write must follow the valid-clear.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (drain) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PW'(1);
    end
    if (enq) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].addr  = address[ADDR_W-1:2];
      entries_d[tail_q].data  = foutput2_ex_mm;
      tail_d                  = tail_q + PW'(1);
    end
    count_d = count_q + CW'(enq) - CW'(drain);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected drains and load results are queued
// at stimulus time from a program-order memory image and compared at DUT output.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        MemRead_ex_mm, MemWrite_ex_mm, flush_ex_mm, mem_ready;
  logic [31:0] foutput2_ex_mm, mem_rdata;
  logic [31:0] mem_address, mem_wdata, load_data;
  logic        mem_read, mem_write, stall, sb_empty;
  logic [2:0]  sb_count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .MemRead_ex_mm  (MemRead_ex_mm),
    .MemWrite_ex_mm (MemWrite_ex_mm),
    .foutput2_ex_mm (foutput2_ex_mm),
    .flush_ex_mm    (flush_ex_mm),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .load_data      (load_data),
    .stall          (stall),
    .sb_empty       (sb_empty),
    .sb_count       (sb_count)
  );

  logic [31:0] tb_mem  [0:63];
  logic [31:0] ref_mem [0:63];
  logic [63:0] exp_wr [$];
  logic [31:0] exp_ld [$];
  int          n_checks = 0;
  int          n_errors = 0;

  assign mem_rdata = tb_mem[mem_address[7:2]];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset && mem_write && mem_ready) begin
      tb_mem[mem_address[7:2]] <= mem_wdata;
      if (exp_wr.size() == 0) begin
        check("wr_unexpected", mem_address, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_wr.pop_front();
        check("wr_addr", mem_address, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_st(input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    address = a; foutput2_ex_mm = d; MemWrite_ex_mm = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!stall) begin ok = 1; break; end
      step();
    end
    if (!ok) check("st_timeout", 32'd1, 32'd0);
    else begin
      exp_wr.push_back({a, d});
      ref_mem[a[7:2]] = d;
    end
    step();
    MemWrite_ex_mm = 1'b0;
  endtask

  task automatic do_ld(input string tag, input logic [31:0] a);
    address = a; MemRead_ex_mm = 1'b1;
    exp_ld.push_back(ref_mem[a[7:2]]);
    @(negedge clk);
    check({tag, "_data"}, load_data, exp_ld.pop_front());
    check({tag, "_rd"}, {31'd0, mem_read}, 32'd1);
    check({tag, "_wr"}, {31'd0, mem_write}, 32'd0);
    step();
    MemRead_ex_mm = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    bit ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (sb_count == 3'd0) begin ok = 1; break; end
    end
    if (!ok) check({tag, "_drain_timeout"}, {29'd0, sb_count}, 32'd0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin tb_mem[i] = '0; ref_mem[i] = '0; end
    tb_mem[3] = 32'h19; ref_mem[3] = 32'h19;
    reset = 1'b1; address = '0; MemRead_ex_mm = 1'b0; MemWrite_ex_mm = 1'b0;
    foutput2_ex_mm = '0; flush_ex_mm = 1'b0; mem_ready = 1'b1;
    step(); step();
    @(negedge clk);
    check("rst_count", {29'd0, sb_count}, 32'd0);
    check("rst_empty", {31'd0, sb_empty}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    step();
    reset = 1'b0;

    // 1: single store drains in the next idle cycle
    do_st(32'h8, 32'h11);
    @(negedge clk);
    check("t1_count1", {29'd0, sb_count}, 32'd1);
    check("t1_mem_write", {31'd0, mem_write}, 32'd1);
    check("t1_addr", mem_address, 32'h8);
    check("t1_wdata", mem_wdata, 32'h11);
    step();
    @(negedge clk);
    check("t1_count0", {29'd0, sb_count}, 32'd0);
    check("t1_empty", {31'd0, sb_empty}, 32'd1);
    step();

    // 2: back-to-back stores to one word, then load forwards the youngest
    do_st(32'h8, 32'h11);
    do_st(32'h8, 32'h22);
    do_ld("t2_ld", 32'h8);
    wait_empty("t2");

    // 3: load with no buffered match reads Data_mem
    do_ld("t3_ld", 32'hC);

    // 4: fill with mem_ready low, stall on the fifth store, release
    mem_ready = 1'b0;
    do_st(32'h10, 32'h30);
    do_st(32'h20, 32'h31);
    do_st(32'h20, 32'h32);
    do_st(32'h14, 32'h33);
    @(negedge clk);
    check("t4_full_count", {29'd0, sb_count}, 32'd4);
    step();
    do_ld("t4_ld", 32'h20);
    address = 32'h18; foutput2_ex_mm = 32'h35; MemWrite_ex_mm = 1'b1;
    @(negedge clk);
    check("t4_stall", {31'd0, stall}, 32'd1);
    step();
    @(negedge clk);
    check("t4_stall_hold", {31'd0, stall}, 32'd1);
    check("t4_hold_count", {29'd0, sb_count}, 32'd4);
    step();
    mem_ready = 1'b1;
    #1;
    @(negedge clk);
    check("t4_unstall", {31'd0, stall}, 32'd0);
    check("t4_drain_addr", mem_address, 32'h10);
    exp_wr.push_back({32'h18, 32'h35});
    ref_mem[6] = 32'h35;
    step();
    MemWrite_ex_mm = 1'b0;
    @(negedge clk);
    check("t4_count_kept", {29'd0, sb_count}, 32'd4);
    wait_empty("t4");

    // 5: flushed store is dropped
    address = 32'h24; foutput2_ex_mm = 32'h99; MemWrite_ex_mm = 1'b1; flush_ex_mm = 1'b1;
    @(negedge clk);
    check("t5_stall", {31'd0, stall}, 32'd0);
    check("t5_mem_write", {31'd0, mem_write}, 32'd0);
    step();
    MemWrite_ex_mm = 1'b0; flush_ex_mm = 1'b0;
    @(negedge clk);
    check("t5_count", {29'd0, sb_count}, 32'd0);
    step();

    // 6: reset with three stores pending drops them
    mem_ready = 1'b0;
    do_st(32'h28, 32'h41);
    do_st(32'h2C, 32'h42);
    do_st(32'h30, 32'h43);
    @(negedge clk);
    check("t6_count3", {29'd0, sb_count}, 32'd3);
    step();
    reset = 1'b1;
    exp_wr.delete();
    step();
    @(negedge clk);
    check("t6_count0", {29'd0, sb_count}, 32'd0);
    check("t6_empty", {31'd0, sb_empty}, 32'd1);
    check("t6_mem_write", {31'd0, mem_write}, 32'd0);
    step();
    reset = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("t6_not_written", tb_mem[10], 32'd0);
    check("wr_pending", exp_wr.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
